// File: rtl/ysyx_23060059_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-master AXI4 arbiter feeding the xbar.
// One transaction in flight at a time; the ungranted side and the idle state see all-zero outputs.
module ysyx_23060059_axi_arbiter #(
  parameter bit FAIR   = 1'b1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                clock,
  input  logic                reset,
  // IFU read
  input  logic [ADDR_W-1:0]   i_araddr,
  input  logic                i_arvalid,
  input  logic [3:0]          i_arid,
  input  logic [7:0]          i_arlen,
  input  logic [2:0]          i_arsize,
  input  logic [1:0]          i_arburst,
  output logic                i_arready,
  input  logic                i_rready,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_rvalid,
  output logic [1:0]          i_rresp,
  output logic [3:0]          i_rid,
  output logic                i_rlast,
  // LSU read
  input  logic [ADDR_W-1:0]   l_araddr,
  input  logic                l_arvalid,
  input  logic [3:0]          l_arid,
  input  logic [7:0]          l_arlen,
  input  logic [2:0]          l_arsize,
  input  logic [1:0]          l_arburst,
  output logic                l_arready,
  input  logic                l_rready,
  output logic [DATA_W-1:0]   l_rdata,
  output logic                l_rvalid,
  output logic [1:0]          l_rresp,
  output logic [3:0]          l_rid,
  output logic                l_rlast,
  // LSU write
  input  logic [ADDR_W-1:0]   l_awaddr,
  input  logic                l_awvalid,
  input  logic [3:0]          l_awid,
  input  logic [7:0]          l_awlen,
  input  logic [2:0]          l_awsize,
  input  logic [1:0]          l_awburst,
  output logic                l_awready,
  input  logic [DATA_W-1:0]   l_wdata,
  input  logic [DATA_W/8-1:0] l_wstrb,
  input  logic                l_wvalid,
  input  logic                l_wlast,
  output logic                l_wready,
  input  logic                l_bready,
  output logic                l_bvalid,
  output logic [1:0]          l_bresp,
  // downstream (xbar)
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  output logic [3:0]          arid,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  input  logic                arready,
  output logic                rready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                rvalid,
  input  logic [1:0]          rresp,
  input  logic [3:0]          rid,
  input  logic                rlast,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  output logic [3:0]          awid,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  output logic                wlast,
  input  logic                wready,
  output logic                bready,
  input  logic                bvalid,
  input  logic [1:0]          bresp
);

  typedef enum logic [1:0] {IDLE, RD_I, RD_L, WR_L} state_e;

  state_e state_q, state_d;
  logic   ar_done_q, ar_done_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;
  logic   last_l_q, last_l_d;   // last completed read grant: 0 = I, 1 = L

  always_comb begin
    state_d   = state_q;
    ar_done_d = ar_done_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    last_l_d  = last_l_q;
    case (state_q)
      IDLE: begin
        if (l_awvalid)
          state_d = WR_L;
        else if (i_arvalid && l_arvalid)
          state_d = (!FAIR || !last_l_q) ? RD_L : RD_I;
        else if (l_arvalid)
          state_d = RD_L;
        else if (i_arvalid)
          state_d = RD_I;
      end
      RD_I, RD_L: begin
        if (arvalid && arready)
          ar_done_d = 1'b1;
        // only the final beat of the burst releases the grant
        if (rvalid && rready && rlast) begin
          state_d   = IDLE;
          ar_done_d = 1'b0;
          last_l_d  = (state_q == RD_L);
        end
      end
      WR_L: begin
        if (awvalid && awready)
          aw_done_d = 1'b1;
        if (wvalid && wready && wlast)
          w_done_d = 1'b1;
        if (bvalid && bready) begin
          state_d   = IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      last_l_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      last_l_q  <= last_l_d;
    end
  end

  always_comb begin
    i_arready = 1'b0;  i_rdata = '0;  i_rvalid = 1'b0;  i_rresp = '0;  i_rid = '0;  i_rlast = 1'b0;
    l_arready = 1'b0;  l_rdata = '0;  l_rvalid = 1'b0;  l_rresp = '0;  l_rid = '0;  l_rlast = 1'b0;
    l_awready = 1'b0;  l_wready = 1'b0;  l_bvalid = 1'b0;  l_bresp = '0;
    araddr = '0;  arvalid = 1'b0;  arid = '0;  arlen = '0;  arsize = '0;  arburst = '0;  rready = 1'b0;
    awaddr = '0;  awvalid = 1'b0;  awid = '0;  awlen = '0;  awsize = '0;  awburst = '0;
    wdata = '0;  wstrb = '0;  wvalid = 1'b0;  wlast = 1'b0;  bready = 1'b0;
    case (state_q)
      RD_I: begin
        araddr = i_araddr;  arid = i_arid;  arlen = i_arlen;  arsize = i_arsize;  arburst = i_arburst;
        arvalid   = i_arvalid & ~ar_done_q;
        i_arready = arready & ~ar_done_q;
        rready    = i_rready;
        i_rdata = rdata;  i_rvalid = rvalid;  i_rresp = rresp;  i_rid = rid;  i_rlast = rlast;
      end
      RD_L: begin
        araddr = l_araddr;  arid = l_arid;  arlen = l_arlen;  arsize = l_arsize;  arburst = l_arburst;
        arvalid   = l_arvalid & ~ar_done_q;
        l_arready = arready & ~ar_done_q;
        rready    = l_rready;
        l_rdata = rdata;  l_rvalid = rvalid;  l_rresp = rresp;  l_rid = rid;  l_rlast = rlast;
      end
      WR_L: begin
        awaddr = l_awaddr;  awid = l_awid;  awlen = l_awlen;  awsize = l_awsize;  awburst = l_awburst;
        awvalid   = l_awvalid & ~aw_done_q;
        l_awready = awready & ~aw_done_q;
        wdata = l_wdata;  wstrb = l_wstrb;  wlast = l_wlast;
        wvalid   = l_wvalid & ~w_done_q;
        l_wready = wready & ~w_done_q;
        bready   = l_bready;
        l_bvalid = bvalid;
        l_bresp  = bresp;
      end
      default: ;
    endcase
  end

endmodule
